register_file: RTL and testbench

- Architectural register file with rename status. Sits downstream of the reorder buffer's commit port and beside the dispatcher.
- Holds 32 x 32-bit values. Each register carries a busy bit and the RoB tag of its youngest in-flight producer.
- Dispatcher renames rd on issue and looks up rs1/rs2. The RoB commit writes values and clears busy when the tag matches.
- Flush clears all rename state; committed values are kept.

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file.sv | 91 +++++++++
 tb/tb_register_file.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: constants shared by the RoB, dispatcher and register file.
package register_file_pkg;
    localparam int ROB_WIDTH  = 3;
    localparam int REG_COUNT  = 32;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

// File: rtl/register_file.sv
// register_file: architectural registers with busy/tag rename state, RoB commit
// write-back, flush of rename state and two combinational source lookups.
module register_file
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  commit_en,
    input  logic [REG_ADDR_W-1:0] commit_reg,
    input  logic [RoB_WIDTH-1:0]  commit_index,
    input  logic [XLEN-1:0]       commit_data,
    input  logic                  rename_en,
    input  logic [REG_ADDR_W-1:0] rename_reg,
    input  logic [RoB_WIDTH-1:0]  rename_index,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_ready,
    output logic [XLEN-1:0]       rs1_value,
    output logic [RoB_WIDTH-1:0]  rs1_tag,
    output logic                  rs2_ready,
    output logic [XLEN-1:0]       rs2_value,
    output logic [RoB_WIDTH-1:0]  rs2_tag
);
    localparam int LW = 1 + XLEN + RoB_WIDTH;

    logic [XLEN-1:0]      value_q [REG_COUNT];
    logic [XLEN-1:0]      value_d [REG_COUNT];
    logic [RoB_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [RoB_WIDTH-1:0] tag_d   [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = commit_en && commit_reg != '0;
    assign rename_ok = rename_en && rename_reg != '0;

    // A busy register whose producer commits this cycle is forwarded from the commit bus.
    function automatic logic [LW-1:0] lookup(input logic [REG_ADDR_W-1:0] r);
        logic bypass;
        bypass = commit_en && commit_reg == r && commit_index == tag_q[r];
        if (r == '0)
            return {1'b1, {XLEN{1'b0}}, {RoB_WIDTH{1'b0}}};
        if (!busy_q[r])
            return {1'b1, value_q[r], {RoB_WIDTH{1'b0}}};
        if (bypass)
            return {1'b1, commit_data, {RoB_WIDTH{1'b0}}};
        return {1'b0, {XLEN{1'b0}}, tag_q[r]};
    endfunction

    assign {rs1_ready, rs1_value, rs1_tag} = lookup(rs1_addr);
    assign {rs2_ready, rs2_value, rs2_tag} = lookup(rs2_addr);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_ok) begin
            value_d[commit_reg] = commit_data;
            if (tag_q[commit_reg] == commit_index)
                busy_d[commit_reg] = 1'b0;
        end
        if (flush_in) begin
            busy_d = '0;
            for (int i = 0; i < REG_COUNT; i++)
                tag_d[i] = '0;
        end else if (rename_ok) begin
            busy_d[rename_reg] = 1'b1;
            tag_d[rename_reg]  = rename_index;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed stimulus against a behavioural model;
// expectations are queued by the driver and checked by an independent monitor.
module tb_register_file;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        commit_en = 1'b0;
    logic [4:0]  commit_reg = '0;
    logic [2:0]  commit_index = '0;
    logic [31:0] commit_data = '0;
    logic        rename_en = 1'b0;
    logic [4:0]  rename_reg = '0;
    logic [2:0]  rename_index = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_value, rs2_value;
    logic [2:0]  rs1_tag, rs2_tag;

    register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
        .commit_data(commit_data), .rename_en(rename_en), .rename_reg(rename_reg),
        .rename_index(rename_index), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_ready(rs1_ready), .rs1_value(rs1_value), .rs1_tag(rs1_tag),
        .rs2_ready(rs2_ready), .rs2_value(rs2_value), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [35:0] rs1;
        logic [35:0] rs2;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [2:0]  m_tag  [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0;
            m_busy[i] = 0;
            m_tag[i] = 0;
        end
    endfunction

    // Expected {ready, value, tag} of a source read under the current inputs.
    function automatic logic [35:0] expect_read(input logic [4:0] r);
        if (!rst_in || r == 0) return {1'b1, 32'd0, 3'd0};
        if (!m_busy[r]) return {1'b1, m_val[r], 3'd0};
        if (commit_en && commit_reg == r && commit_index == m_tag[r])
            return {1'b1, commit_data, 3'd0};
        return {1'b0, 32'd0, m_tag[r]};
    endfunction

    function automatic void model_clock();
        int c, n;
        bit retire;
        if (!rst_in || !rdy_in) return;
        c = int'(commit_reg);
        n = int'(rename_reg);
        retire = commit_en && c != 0 && m_tag[c] == commit_index;
        if (commit_en && c != 0) m_val[c] = commit_data;
        if (flush_in) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 0;
                m_tag[i] = 0;
            end
        end else begin
            if (retire) m_busy[c] = 0;
            if (rename_en && n != 0) begin
                m_busy[n] = 1;
                m_tag[n] = rename_index;
            end
        end
    endfunction

    task automatic check_now();
        exp_t e;
        e.rs1 = expect_read(rs1_addr);
        e.rs2 = expect_read(rs2_addr);
        sb.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic cycle();
        check_now();
        @(posedge clk_in);
        model_clock();
        #1;
    endtask

    task automatic drive(input bit ce, input int cr, input int ci, input logic [31:0] cd,
                         input bit re, input int rr, input int ri,
                         input int a1, input int a2, input bit fl, input bit rdy);
        commit_en = ce; commit_reg = 5'(cr); commit_index = 3'(ci); commit_data = cd;
        rename_en = re; rename_reg = 5'(rr); rename_index = 3'(ri);
        rs1_addr = 5'(a1); rs2_addr = 5'(a2); flush_in = fl; rdy_in = rdy;
        cycle();
    endtask

    task automatic idle(input int a1, input int a2);
        drive(0, 0, 0, 0, 0, 0, 0, a1, a2, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors += 2;
                if ({rs1_ready, rs1_value, rs1_tag} !== e.rs1) begin
                    miscompares++;
                    $display("FAIL rs1 x%0d t=%0t: got rdy=%b val=%h tag=%0d, want rdy=%b val=%h tag=%0d",
                             rs1_addr, $time, rs1_ready, rs1_value, rs1_tag, e.rs1[35], e.rs1[34:3], e.rs1[2:0]);
                end
                if ({rs2_ready, rs2_value, rs2_tag} !== e.rs2) begin
                    miscompares++;
                    $display("FAIL rs2 x%0d t=%0t: got rdy=%b val=%h tag=%0d, want rdy=%b val=%h tag=%0d",
                             rs2_addr, $time, rs2_ready, rs2_value, rs2_tag, e.rs2[35], e.rs2[34:3], e.rs2[2:0]);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        model_reset();
        #1;
        idle(5, 0);
        idle(1, 31);
        rst_in = 1'b1;
        idle(5, 0);
        // rename then commit with same-cycle bypass
        drive(0, 0, 0, 0, 1, 5, 3, 5, 6, 0, 1);
        idle(5, 0);
        drive(1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 5, 6, 0, 1);
        idle(5, 6);
        // stale commit leaves the younger rename in place
        drive(0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 7, 4, 7, 0, 0, 1);
        drive(1, 7, 1, 32'h11, 0, 0, 0, 7, 0, 0, 1);
        idle(7, 0);
        drive(1, 7, 4, 32'h22, 0, 0, 0, 7, 0, 0, 1);
        idle(7, 0);
        // simultaneous commit and rename of the same register
        drive(0, 0, 0, 0, 1, 9, 2, 9, 0, 0, 1);
        drive(1, 9, 2, 32'h55, 1, 9, 6, 9, 0, 0, 1);
        idle(9, 0);
        drive(1, 9, 6, 32'h66, 0, 0, 0, 9, 0, 0, 1);
        idle(9, 0);
        // flush drops rename state and the same-cycle rename
        drive(1, 3, 0, 32'h33, 0, 0, 0, 3, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 3, 5, 3, 4, 0, 1);
        drive(0, 0, 0, 0, 1, 4, 6, 3, 4, 0, 1);
        idle(3, 4);
        drive(0, 0, 0, 0, 1, 8, 7, 3, 4, 1, 1);
        idle(3, 4);
        idle(8, 0);
        // x0 and rdy_in hold
        drive(1, 0, 0, 32'hFF, 1, 0, 1, 0, 0, 0, 1);
        idle(0, 0);
        drive(0, 0, 0, 0, 1, 10, 2, 10, 0, 0, 0);
        idle(10, 0);
        drive(1, 5, 0, 32'h1234, 0, 0, 0, 5, 0, 0, 0);
        idle(5, 0);
        // randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst_in = 1'b0;
                model_reset();
                check_now();
                @(posedge clk_in);
                #1;
                check_now();
                rst_in = 1'b1;
                #1;
                idle(5, int'($urandom_range(0, 31)));
            end
            drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 7),
                  $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);
        end
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(posedge clk_in);
            budget++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
